// File: rtl/usb_endpoint_table_parser_if.sv
// Descriptor byte stream: one byte per valid/ready handshake, desc_last marks the final byte.
interface usb_endpoint_table_parser_if;
    logic [7:0] desc_data;
    logic       desc_valid;
    logic       desc_last;
    logic       desc_ready;

    modport master (output desc_data, output desc_valid, output desc_last, input desc_ready);
    modport slave  (input desc_data, input desc_valid, input desc_last, output desc_ready);
endinterface

// File: rtl/usb_endpoint_table_parser.sv
// USB configuration descriptor walker: collects endpoints of matching interfaces
// into a small register table read by the transfer scheduler.
// Build option: USB_EPT_ALTSET_FILTER_EN restricts interface matches to bAlternateSetting 0.
module usb_endpoint_table_parser #(
    parameter int unsigned MAX_ENDPOINTS = 4,
    parameter int unsigned IDX_W         = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    usb_endpoint_table_parser_if.slave stream,
    input  logic [7:0]                 filter_class,
    input  logic [7:0]                 filter_subclass,
    input  logic [7:0]                 filter_protocol,
    input  logic [3:0]                 filter_type_mask,
    input  logic [1:0]                 filter_dir_mode,
    output logic                       done,
    output logic                       error,
    output logic                       overflow,
    output logic [IDX_W:0]             ep_count,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [3:0]                 rd_number,
    output logic                       rd_dir,
    output logic [1:0]                 rd_type,
    output logic [10:0]                rd_max_packet,
    output logic [7:0]                 rd_interval,
    output logic [7:0]                 rd_iface_num,
    output logic [7:0]                 rd_iface_protocol
);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERROR} state_t;

    typedef struct packed {
        logic [3:0]  number;
        logic        dir;
        logic [1:0]  xfer_type;
        logic [10:0] max_packet;
        logic [7:0]  interval;
        logic [7:0]  iface_num;
        logic [7:0]  iface_protocol;
    } entry_t;

    state_t      state, state_next;
    logic        ready_q;

    logic [7:0]  offset, blen, dtype;
    logic [15:0] byte_cnt, wtotal;
    logic        first_desc, match_flag;
    logic [7:0]  if_num, if_class, if_sub, if_proto;
`ifdef USB_EPT_ALTSET_FILTER_EN
    logic [7:0]  if_alt;
`endif
    logic [3:0]  ep_number;
    logic        ep_dir;
    logic [1:0]  ep_type;
    logic [7:0]  ep_mps_lo;
    logic [2:0]  ep_mps_hi;
    entry_t      table_q [MAX_ENDPOINTS];

    logic        accept, clear, take, wr, set_ovf;
    logic [7:0]  cur_len, cur_type;
    logic [15:0] cnt_next;
    logic        desc_end, stream_end, table_full;
    logic        iface_ok, type_ok, dir_ok, ep_hit;
    entry_t      new_entry, rd_entry;

    assign stream.desc_ready = ready_q;

    // Per-byte decode: live length/type on the first two bytes, descriptor/stream end, filters.
    always_comb begin
        accept     = stream.desc_valid & ready_q;
        cur_len    = (offset == 8'd0) ? stream.desc_data : blen;
        cur_type   = (offset == 8'd1) ? stream.desc_data : dtype;
        desc_end   = (offset == cur_len - 8'd1);
        cnt_next   = byte_cnt + 16'd1;
        stream_end = stream.desc_last | ((wtotal != 16'd0) && (cnt_next == wtotal));
        table_full = (ep_count == CNT_W'(MAX_ENDPOINTS));
        iface_ok   = (if_class == filter_class)
                   && ((filter_subclass == 8'hFF) || (if_sub == filter_subclass))
                   && ((filter_protocol == 8'hFF) || (if_proto == filter_protocol));
`ifdef USB_EPT_ALTSET_FILTER_EN
        iface_ok   = iface_ok && (if_alt == 8'd0);
`endif
        type_ok    = filter_type_mask[ep_type];
        case (filter_dir_mode)
            2'b00:   dir_ok = 1'b1;
            2'b01:   dir_ok = ~ep_dir;
            2'b10:   dir_ok = ep_dir;
            default: dir_ok = 1'b0;
        endcase
        ep_hit     = desc_end && (cur_type == 8'h05) && match_flag && type_ok && dir_ok;
        new_entry  = '{number: ep_number, dir: ep_dir, xfer_type: ep_type,
                       max_packet: {ep_mps_hi, ep_mps_lo}, interval: stream.desc_data,
                       iface_num: if_num, iface_protocol: if_proto};
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        take       = 1'b0;
        wr         = 1'b0;
        set_ovf    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    clear      = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (accept) begin
                    take = 1'b1;
                    if (cur_len < 8'd2) begin
                        state_next = S_ERROR;
                    end else if (stream.desc_last && !desc_end) begin
                        state_next = S_ERROR;
                    end else if (ep_hit && table_full) begin
                        set_ovf    = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        wr = ep_hit;
                        if (stream_end) state_next = S_DONE;
                    end
                end
            end
            default: begin
                if (!enable) state_next = S_IDLE;
            end
        endcase
    end

    // State register with registered handshake/status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == S_RUN);
            done    <= (state_next == S_DONE) || (state_next == S_ERROR);
            error   <= (state_next == S_ERROR);
        end
    end

    // Descriptor walker: offsets, byte count, field latches and table writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset     <= '0;
            blen       <= '0;
            dtype      <= '0;
            byte_cnt   <= '0;
            wtotal     <= '0;
            first_desc <= 1'b0;
            match_flag <= 1'b0;
            if_num     <= '0;
            if_class   <= '0;
            if_sub     <= '0;
            if_proto   <= '0;
`ifdef USB_EPT_ALTSET_FILTER_EN
            if_alt     <= '0;
`endif
            ep_number  <= '0;
            ep_dir     <= 1'b0;
            ep_type    <= '0;
            ep_mps_lo  <= '0;
            ep_mps_hi  <= '0;
            ep_count   <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < int'(MAX_ENDPOINTS); i++) table_q[i] <= '0;
        end else if (clear) begin
            offset     <= '0;
            byte_cnt   <= '0;
            wtotal     <= '0;
            first_desc <= 1'b1;
            match_flag <= 1'b0;
            ep_count   <= '0;
            overflow   <= 1'b0;
        end else if (take) begin
            byte_cnt <= cnt_next;
            if (desc_end) begin
                offset     <= '0;
                first_desc <= 1'b0;
            end else begin
                offset <= offset + 8'd1;
            end
            if (offset == 8'd0) blen  <= stream.desc_data;
            if (offset == 8'd1) dtype <= stream.desc_data;
            if (first_desc && (cur_type == 8'h02)) begin
                if (offset == 8'd2) wtotal[7:0]  <= stream.desc_data;
                if (offset == 8'd3) wtotal[15:8] <= stream.desc_data;
            end
            if (cur_type == 8'h04) begin
                case (offset)
                    8'd2: if_num <= stream.desc_data;
`ifdef USB_EPT_ALTSET_FILTER_EN
                    8'd3: if_alt <= stream.desc_data;
`endif
                    8'd5: if_class <= stream.desc_data;
                    8'd6: if_sub   <= stream.desc_data;
                    8'd7: if_proto <= stream.desc_data;
                    default: ;
                endcase
                if (desc_end) match_flag <= iface_ok;
            end
            if (cur_type == 8'h05) begin
                case (offset)
                    8'd2: begin
                        ep_number <= stream.desc_data[3:0];
                        ep_dir    <= stream.desc_data[7];
                    end
                    8'd3: ep_type   <= stream.desc_data[1:0];
                    8'd4: ep_mps_lo <= stream.desc_data;
                    8'd5: ep_mps_hi <= stream.desc_data[2:0];
                    default: ;
                endcase
            end
            if (wr) begin
                table_q[ep_count[IDX_W-1:0]] <= new_entry;
                ep_count <= ep_count + CNT_W'(1);
            end
            if (set_ovf) overflow <= 1'b1;
        end
    end

    // Combinational table read; slots past ep_count read as zero.
    always_comb begin
        rd_entry = '0;
        if (CNT_W'(rd_idx) < ep_count) rd_entry = table_q[rd_idx];
    end

    assign rd_number         = rd_entry.number;
    assign rd_dir            = rd_entry.dir;
    assign rd_type           = rd_entry.xfer_type;
    assign rd_max_packet     = rd_entry.max_packet;
    assign rd_interval       = rd_entry.interval;
    assign rd_iface_num      = rd_entry.iface_num;
    assign rd_iface_protocol = rd_entry.iface_protocol;
endmodule

// File: tb/tb_usb_endpoint_table_parser.sv
// Directed bench for usb_endpoint_table_parser (table depth 2 so overflow is reachable).
module tb_usb_endpoint_table_parser;
    localparam int unsigned MAX_EP = 2;
    localparam int unsigned IDX_W  = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [7:0]       filter_class = '0, filter_subclass = '0, filter_protocol = '0;
    logic [3:0]       filter_type_mask = '0;
    logic [1:0]       filter_dir_mode = '0;
    logic             done, error, overflow;
    logic [IDX_W:0]   ep_count;
    logic [IDX_W-1:0] rd_idx = '0;
    logic [3:0]       rd_number;
    logic             rd_dir;
    logic [1:0]       rd_type;
    logic [10:0]      rd_max_packet;
    logic [7:0]       rd_interval, rd_iface_num, rd_iface_protocol;

    usb_endpoint_table_parser_if bus ();

    usb_endpoint_table_parser #(.MAX_ENDPOINTS(MAX_EP), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stream(bus),
        .filter_class(filter_class), .filter_subclass(filter_subclass),
        .filter_protocol(filter_protocol), .filter_type_mask(filter_type_mask),
        .filter_dir_mode(filter_dir_mode), .done(done), .error(error),
        .overflow(overflow), .ep_count(ep_count), .rd_idx(rd_idx),
        .rd_number(rd_number), .rd_dir(rd_dir), .rd_type(rd_type),
        .rd_max_packet(rd_max_packet), .rd_interval(rd_interval),
        .rd_iface_num(rd_iface_num), .rd_iface_protocol(rd_iface_protocol)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stream;
        bit         gap;
        logic [7:0] fc, fs, fp;
        logic [3:0] mask;
        logic [1:0] dmode;
        bit         e_err, e_ovf;
        int         e_cnt, e_bytes;
        logic [3:0] e_num;
        logic       e_dir;
        logic [1:0] e_type;
        logic [10:0] e_mps;
        logic [7:0] e_int, e_if, e_proto;
        logic [3:0] e1_num;
    } vec_t;

    vec_t       vecs [13];
    logic [7:0] sb [$];
    bit         sl [$];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        sb.push_back(b);
        sl.push_back(1'b0);
    endtask

    task automatic put_cfg(input logic [15:0] wtl);
        put(8'h09); put(8'h02); put(wtl[7:0]); put(wtl[15:8]);
        put(8'h01); put(8'h01); put(8'h00); put(8'hA0); put(8'h32);
    endtask

    task automatic put_if(input logic [7:0] num, alt, neps, cls, sub, proto);
        put(8'h09); put(8'h04); put(num); put(alt); put(neps);
        put(cls); put(sub); put(proto); put(8'h00);
    endtask

    task automatic put_hid();
        put(8'h09); put(8'h21); put(8'h11); put(8'h01); put(8'h00);
        put(8'h01); put(8'h22); put(8'h3F); put(8'h00);
    endtask

    task automatic put_ep(input logic [7:0] addr, attr, mlo, mhi, intv);
        put(8'h07); put(8'h05); put(addr); put(attr); put(mlo); put(mhi); put(intv);
    endtask

    task automatic build(input int id);
        sb.delete();
        sl.delete();
        case (id)
            0: begin
                put_cfg(16'd34); put_if(8'h00, 8'h00, 8'h01, 8'h03, 8'h01, 8'h01);
                put_hid(); put_ep(8'h81, 8'h03, 8'h08, 8'h00, 8'h0A);
            end
            1: begin
                put_cfg(16'd46); put_if(8'h01, 8'h00, 8'h04, 8'h08, 8'h06, 8'h50);
                put_ep(8'h81, 8'h02, 8'h00, 8'h02, 8'h00);
                put_ep(8'h82, 8'h02, 8'h00, 8'h02, 8'h00);
                put_ep(8'h83, 8'h02, 8'h00, 8'h02, 8'h00);
                put_ep(8'h04, 8'h02, 8'h00, 8'h02, 8'h00);
            end
            2: begin
                put_cfg(16'd34); put(8'h01); put(8'h04); put(8'h00); put(8'h00); put(8'h00);
            end
            3: begin
                put_cfg(16'd34); put_if(8'h00, 8'h00, 8'h01, 8'h03, 8'h01, 8'h01); put_hid();
                put(8'h07); put(8'h05); put(8'h81); put(8'h03); put(8'h08);
                sl[sl.size()-1] = 1'b1;
                put(8'h00); put(8'h0A);
            end
            4: begin
                put_cfg(16'd34);
                put_if(8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 8'h01);
                put_if(8'h00, 8'h01, 8'h01, 8'h03, 8'h01, 8'h01);
                put_ep(8'h82, 8'h03, 8'h08, 8'h00, 8'h0A);
            end
            default: begin
                put_cfg(16'd0); put_if(8'h00, 8'h00, 8'h01, 8'h03, 8'h01, 8'h01); put_hid();
                put(8'h03); put(8'hFF); put(8'hAA);
                put_ep(8'h81, 8'h03, 8'h08, 8'h00, 8'h0A);
                sl[sl.size()-1] = 1'b1;
            end
        endcase
    endtask

    // Feeds sb/sl while ready; stops on done, after stop_after accepted bytes, or on budget expiry.
    task automatic run_stream(input bit gap, input int stop_after,
                              output int consumed, output int lat, output bit timed_out);
        int  idx = 0;
        int  last_c = -100;
        bit  phase = 1'b1;
        consumed  = 0;
        lat       = -1;
        timed_out = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c - last_c;
                timed_out = 1'b0;
                break;
            end
            if (stop_after != 0 && consumed == stop_after) begin
                timed_out = 1'b0;
                break;
            end
            if (idx < sb.size() && (!gap || phase)) begin
                bus.desc_valid = 1'b1;
                bus.desc_data  = sb[idx];
                bus.desc_last  = sl[idx];
                if (bus.desc_ready) begin
                    idx++;
                    consumed++;
                    last_c = c;
                end
            end else begin
                bus.desc_valid = 1'b0;
                bus.desc_data  = 8'h00;
                bus.desc_last  = 1'b0;
            end
            phase = ~phase;
        end
        bus.desc_valid = 1'b0;
        bus.desc_last  = 1'b0;
    endtask

    task automatic start(input logic [7:0] fc, fs, fp, input logic [3:0] m, input logic [1:0] d);
        @(negedge clk);
        enable = 1'b0;
        filter_class = fc; filter_subclass = fs; filter_protocol = fp;
        filter_type_mask = m; filter_dir_mode = d;
        repeat (2) @(negedge clk);
        enable = 1'b1;
    endtask

    function automatic vec_t mk(input int s, input bit g, input logic [7:0] fc, fs, fp,
                                input logic [3:0] m, input logic [1:0] d, input bit er, ov,
                                input int cnt, by, input logic [3:0] num, input logic dir,
                                input logic [1:0] ty, input logic [10:0] mps,
                                input logic [7:0] iv, ifn, pr, input logic [3:0] n1);
        vec_t v;
        v.stream = s; v.gap = g; v.fc = fc; v.fs = fs; v.fp = fp; v.mask = m; v.dmode = d;
        v.e_err = er; v.e_ovf = ov; v.e_cnt = cnt; v.e_bytes = by;
        v.e_num = num; v.e_dir = dir; v.e_type = ty; v.e_mps = mps;
        v.e_int = iv; v.e_if = ifn; v.e_proto = pr; v.e1_num = n1;
        return v;
    endfunction

    initial begin
        int  consumed, lat;
        bit  to;
        bus.desc_valid = 1'b0;
        bus.desc_data  = 8'h00;
        bus.desc_last  = 1'b0;

        vecs[0]  = mk(0, 0, 8'h03, 8'h01, 8'h01, 4'b1000, 2'b10, 0, 0, 1, 34, 4'd1, 1'b1, 2'd3, 11'd8, 8'd10, 8'd0, 8'd1, 4'd0);
        vecs[1]  = mk(0, 1, 8'h03, 8'h01, 8'h01, 4'b1000, 2'b10, 0, 0, 1, 34, 4'd1, 1'b1, 2'd3, 11'd8, 8'd10, 8'd0, 8'd1, 4'd0);
        vecs[2]  = mk(0, 0, 8'h03, 8'hFF, 8'hFF, 4'b1000, 2'b00, 0, 0, 1, 34, 4'd1, 1'b1, 2'd3, 11'd8, 8'd10, 8'd0, 8'd1, 4'd0);
        vecs[3]  = mk(0, 0, 8'h03, 8'h01, 8'h01, 4'b1000, 2'b01, 0, 0, 0, 34, 4'd0, 1'b0, 2'd0, 11'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        vecs[4]  = mk(0, 0, 8'h03, 8'h01, 8'h01, 4'b0111, 2'b10, 0, 0, 0, 34, 4'd0, 1'b0, 2'd0, 11'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        vecs[5]  = mk(0, 0, 8'h08, 8'h01, 8'h01, 4'b1000, 2'b10, 0, 0, 0, 34, 4'd0, 1'b0, 2'd0, 11'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        vecs[6]  = mk(1, 0, 8'h08, 8'hFF, 8'hFF, 4'b0100, 2'b10, 0, 1, 2, 39, 4'd1, 1'b1, 2'd2, 11'd512, 8'd0, 8'd1, 8'h50, 4'd2);
        vecs[7]  = mk(2, 0, 8'h03, 8'h01, 8'h01, 4'b1000, 2'b10, 1, 0, 0, 10, 4'd0, 1'b0, 2'd0, 11'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        vecs[8]  = mk(3, 0, 8'h03, 8'h01, 8'h01, 4'b1000, 2'b10, 1, 0, 0, 32, 4'd0, 1'b0, 2'd0, 11'd0, 8'd0, 8'd0, 8'd0, 4'd0);
`ifdef USB_EPT_ALTSET_FILTER_EN
        vecs[9]  = mk(4, 0, 8'h03, 8'h01, 8'h01, 4'b1000, 2'b10, 0, 0, 0, 34, 4'd0, 1'b0, 2'd0, 11'd0, 8'd0, 8'd0, 8'd0, 4'd0);
`else
        vecs[9]  = mk(4, 0, 8'h03, 8'h01, 8'h01, 4'b1000, 2'b10, 0, 0, 1, 34, 4'd2, 1'b1, 2'd3, 11'd8, 8'd10, 8'd0, 8'd1, 4'd0);
`endif
        vecs[10] = mk(5, 0, 8'h03, 8'h01, 8'h01, 4'b1000, 2'b10, 0, 0, 1, 37, 4'd1, 1'b1, 2'd3, 11'd8, 8'd10, 8'd0, 8'd1, 4'd0);
        vecs[11] = mk(0, 0, 8'h03, 8'h01, 8'h01, 4'b1000, 2'b11, 0, 0, 0, 34, 4'd0, 1'b0, 2'd0, 11'd0, 8'd0, 8'd0, 8'd0, 4'd0);
        vecs[12] = mk(0, 0, 8'h03, 8'h00, 8'h01, 4'b1000, 2'b10, 0, 0, 0, 34, 4'd0, 1'b0, 2'd0, 11'd0, 8'd0, 8'd0, 8'd0, 4'd0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_ep_count", 32'(ep_count), 0);
        chk("rst_ready", 32'(bus.desc_ready), 0);
        chk("rst_rd", 32'(|{rd_number, rd_dir, rd_type, rd_max_packet, rd_interval, rd_iface_num, rd_iface_protocol}), 0);
        rst_n = 1'b1;

        // Table-driven runs
        for (int k = 0; k < 13; k++) begin
            build(vecs[k].stream);
            start(vecs[k].fc, vecs[k].fs, vecs[k].fp, vecs[k].mask, vecs[k].dmode);
            run_stream(vecs[k].gap, 0, consumed, lat, to);
            chk($sformatf("v%0d_timeout", k), 32'(to), 0);
            chk($sformatf("v%0d_done", k), 32'(done), 1);
            chk($sformatf("v%0d_ready", k), 32'(bus.desc_ready), 0);
            chk($sformatf("v%0d_error", k), 32'(error), 32'(vecs[k].e_err));
            chk($sformatf("v%0d_overflow", k), 32'(overflow), 32'(vecs[k].e_ovf));
            chk($sformatf("v%0d_ep_count", k), 32'(ep_count), 32'(vecs[k].e_cnt));
            chk($sformatf("v%0d_bytes", k), 32'(consumed), 32'(vecs[k].e_bytes));
            chk($sformatf("v%0d_done_latency", k), 32'(lat), 1);
            if (vecs[k].e_cnt > 0) begin
                rd_idx = '0;
                #1;
                chk($sformatf("v%0d_number", k), 32'(rd_number), 32'(vecs[k].e_num));
                chk($sformatf("v%0d_dir", k), 32'(rd_dir), 32'(vecs[k].e_dir));
                chk($sformatf("v%0d_type", k), 32'(rd_type), 32'(vecs[k].e_type));
                chk($sformatf("v%0d_mps", k), 32'(rd_max_packet), 32'(vecs[k].e_mps));
                chk($sformatf("v%0d_interval", k), 32'(rd_interval), 32'(vecs[k].e_int));
                chk($sformatf("v%0d_iface", k), 32'(rd_iface_num), 32'(vecs[k].e_if));
                chk($sformatf("v%0d_proto", k), 32'(rd_iface_protocol), 32'(vecs[k].e_proto));
            end
            if (vecs[k].e_cnt > 1) begin
                rd_idx = 1'b1;
                #1;
                chk($sformatf("v%0d_e1_number", k), 32'(rd_number), 32'(vecs[k].e1_num));
            end
            if (vecs[k].e_cnt < int'(MAX_EP)) begin
                rd_idx = IDX_W'(vecs[k].e_cnt);
                #1;
                chk($sformatf("v%0d_empty_slot", k),
                    32'(|{rd_number, rd_dir, rd_type, rd_max_packet, rd_interval, rd_iface_num, rd_iface_protocol}), 0);
            end
        end

        // DONE holds while enable stays high, clears once enable drops
        build(0);
        start(8'h03, 8'h01, 8'h01, 4'b1000, 2'b10);
        run_stream(1'b0, 0, consumed, lat, to);
        chk("hold_timeout", 32'(to), 0);
        repeat (3) @(negedge clk);
        chk("hold_done", 32'(done), 1);
        chk("hold_ready", 32'(bus.desc_ready), 0);
        enable = 1'b0;
        @(negedge clk);
        chk("release_done", 32'(done), 0);

        // Abort after 20 bytes, then a clean re-run
        build(0);
        start(8'h03, 8'h01, 8'h01, 4'b1000, 2'b10);
        run_stream(1'b0, 20, consumed, lat, to);
        chk("abort_bytes", 32'(consumed), 20);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.desc_ready), 0);
        chk("abort_done", 32'(done), 0);
        start(8'h03, 8'h01, 8'h01, 4'b1000, 2'b10);
        run_stream(1'b0, 0, consumed, lat, to);
        chk("rerun_timeout", 32'(to), 0);
        chk("rerun_done", 32'(done), 1);
        chk("rerun_error", 32'(error), 0);
        chk("rerun_ep_count", 32'(ep_count), 1);
        rd_idx = '0;
        #1;
        chk("rerun_number", 32'(rd_number), 1);
        chk("rerun_bytes", 32'(consumed), 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
